// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction field tuples into 32-bit words and streams them into
// instruction memory at consecutive addresses until HALT, an encoding error or overflow.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [2:0]        rd,
    input  logic [2:0]        rs1,
    input  logic [2:0]        rs2,
    input  logic              alu_mode,
    input  logic [2:0]        alu_func,
    input  logic [3:0]        cond,
    input  logic [15:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [3:0]        OP_ALU_I  = 4'd3;
    localparam logic [3:0]        OP_HALT   = 4'd9;
    localparam logic [1:0]        ERR_NONE  = 2'd0;
    localparam logic [1:0]        ERR_ILL   = 2'd1;
    localparam logic [1:0]        ERR_FUNC  = 2'd2;
    localparam logic [1:0]        ERR_OVF   = 2'd3;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_vld_p1;
    logic [31:0]        r_wdata_p1;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W:0]    r_word_cnt;
    logic [1:0]         r_err_code;
    logic               r_halt_pend;
    logic               r_ovf_pend;

    logic               w_accept;
    logic               w_complete;
    logic [1:0]         w_chk;
    logic               w_good;
    logic               w_bad;
    logic               w_is_halt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [31:0]        w_word;

    function automatic logic [1:0] tuple_check(input logic [3:0] f_op, input logic [2:0] f_func);
        logic [1:0] code;
        code = ERR_NONE;
        if (f_op > OP_HALT)
            code = ERR_ILL;
        else if (f_op == OP_ALU_I && f_func[2:1] != 2'b00)
            code = ERR_FUNC;
        return code;
    endfunction

    function automatic logic [31:0] encode_word(
        input logic [3:0]  f_op,
        input logic [2:0]  f_rd,
        input logic [2:0]  f_rs1,
        input logic [2:0]  f_rs2,
        input logic        f_mode,
        input logic [2:0]  f_func,
        input logic [3:0]  f_cond,
        input logic [15:0] f_imm
    );
        logic [31:0] w;
        w        = '0;
        w[24:22] = f_rd;
        w[21:19] = f_rs1;
        w[18:16] = f_rs2;
        w[15:0]  = f_imm;
        case (f_op)
            4'd1: begin w[31:29] = 3'b001; w[28] = 1'b1; end
            4'd2: begin w[31:30] = 2'b01; w[29] = f_mode; w[28] = 1'b1; w[27:25] = f_func; end
            4'd3: begin w[31:30] = 2'b01; w[29] = f_mode; w[25] = f_func[0]; end
            4'd4: w[31:30] = 2'b10;
            4'd5: begin w[31:30] = 2'b10; w[25] = 1'b1; end
            4'd6: w[31:30] = 2'b11;
            // cond owns I[24:21]; it displaces rd and the top bit of the rs1 slot
            4'd7: begin w[31:30] = 2'b11; w[26] = 1'b1; w[24:21] = f_cond; end
            4'd8: begin w[31:30] = 2'b11; w[27] = 1'b1; end
            4'd9: begin w[31:30] = 2'b11; w[28] = 1'b1; end
            default: ;
        endcase
        return w;
    endfunction

    assign in_ready   = (r_state == S_RUN) & ~(r_vld_p1 & mem_stall) & ~r_halt_pend & ~r_ovf_pend;
    assign w_accept   = in_valid & in_ready;
    assign w_complete = r_vld_p1 & ~mem_stall;
    assign w_chk      = tuple_check(op, alu_func);
    assign w_good     = w_accept & (w_chk == ERR_NONE);
    assign w_bad      = w_accept & (w_chk != ERR_NONE);
    assign w_is_halt  = (op == OP_HALT);
    assign w_addr_nxt = r_addr + {{(ADDR_W-1){1'b0}}, w_complete};
    assign w_word     = encode_word(op, rd, rs1, rs2, alu_mode, alu_func, cond, imm);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_bad || (r_ovf_pend && w_complete))
                    w_state_nxt = S_ERR;
                else if (r_halt_pend && w_complete)
                    w_state_nxt = S_DONE;
            end
            default: begin
                if (start)
                    w_state_nxt = S_RUN;
            end
        endcase
    end

    // p0 -> p1: accepted tuple becomes the presented write, held while memory stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_wdata_p1  <= '0;
            r_addr      <= BASE;
            r_word_cnt  <= '0;
            r_err_code  <= ERR_NONE;
            r_halt_pend <= 1'b0;
            r_ovf_pend  <= 1'b0;
        end else if (r_state != S_RUN) begin
            if (start) begin
                r_vld_p1    <= 1'b0;
                r_addr      <= BASE;
                r_word_cnt  <= '0;
                r_err_code  <= ERR_NONE;
                r_halt_pend <= 1'b0;
                r_ovf_pend  <= 1'b0;
            end
        end else begin
            r_vld_p1 <= w_good | (r_vld_p1 & mem_stall);
            r_addr   <= w_addr_nxt;
            if (w_good) begin
                r_wdata_p1  <= w_word;
                r_halt_pend <= w_is_halt;
                r_ovf_pend  <= ~w_is_halt & (&w_addr_nxt);
            end else if (w_complete) begin
                r_halt_pend <= 1'b0;
                r_ovf_pend  <= 1'b0;
            end
            if (w_complete)
                r_word_cnt <= r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};
            if (w_bad)
                r_err_code <= w_chk;
            else if (r_ovf_pend && w_complete)
                r_err_code <= ERR_OVF;
        end
    end

    assign mem_we     = r_vld_p1;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata_p1;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign err_code   = r_err_code;
    assign word_count = r_word_cnt;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the loader.
module tb_instr_encoder_loader;

    localparam int AW    = 2;
    localparam int BASE  = 0;
    localparam int DEPTH = 1 << AW;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

    logic          clk;
    logic          rst_n, start, in_valid, in_ready;
    logic [3:0]    op;
    logic [2:0]    rd, rs1, rs2;
    logic          alu_mode;
    logic [2:0]    alu_func;
    logic [3:0]    cond;
    logic [15:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_stall;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [AW:0]   word_count;

    int total = 0;
    int bad   = 0;

    // model state
    bit          m_live = 0;
    int          m_mode = M_IDLE;
    bit          m_have_wr = 0;
    logic [31:0] m_word = 0;
    int          m_count = 0;
    int          m_code = 0;
    int          m_final = 0;   // 0 none, 1 halt -> DONE, 2 overflow -> ERR

    logic [AW+31:0] wlog[$];

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .alu_mode(alu_mode), .alu_func(alu_func),
        .cond(cond), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .busy(busy), .done(done), .err(err), .err_code(err_code),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_enc(input logic [3:0] e_op, input logic [2:0] e_rd,
                                          input logic [2:0] e_rs1, input logic [2:0] e_rs2,
                                          input logic e_mode, input logic [2:0] e_func,
                                          input logic [3:0] e_cond, input logic [15:0] e_imm);
        logic [31:0] w;
        w = (32'(e_rd) << 22) | (32'(e_rs1) << 19) | (32'(e_rs2) << 16) | 32'(e_imm);
        case (e_op)
            4'd0: w = w;
            4'd1: w = w | 32'h3000_0000;
            4'd2: w = w | 32'h5000_0000 | (32'(e_mode) << 29) | (32'(e_func) << 25);
            4'd3: w = w | 32'h4000_0000 | (32'(e_mode) << 29) | (32'(e_func[0]) << 25);
            4'd4: w = w | 32'h8000_0000;
            4'd5: w = w | 32'h8200_0000;
            4'd6: w = w | 32'hC000_0000;
            4'd7: w = (w & ~32'h01E0_0000) | 32'hC400_0000 | (32'(e_cond) << 21);
            4'd8: w = w | 32'hC800_0000;
            4'd9: w = w | 32'hD000_0000;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic bit m_ready_f();
        return (m_mode == M_RUN) && !(m_have_wr && mem_stall) && (m_final == 0);
    endfunction

    // model advance on each rising edge
    initial begin
        bit acc, cmp;
        int a;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_live = 1; m_mode = M_IDLE; m_have_wr = 0; m_word = 0;
                m_count = 0; m_code = 0; m_final = 0;
            end else if (m_live) begin
                if (m_mode != M_RUN) begin
                    if (start) begin
                        m_mode = M_RUN; m_count = 0; m_code = 0; m_have_wr = 0; m_final = 0;
                    end
                end else begin
                    acc = in_valid && m_ready_f();
                    cmp = m_have_wr && !mem_stall;
                    if (cmp) begin
                        m_count++;
                        m_have_wr = 0;
                        if (m_final == 1) m_mode = M_DONE;
                        else if (m_final == 2) begin m_mode = M_ERR; m_code = 3; end
                        m_final = 0;
                    end
                    if (acc) begin
                        if (op >= 4'd10) begin
                            m_mode = M_ERR; m_code = 1;
                        end else if (op == 4'd3 && alu_func[2:1] != 2'b00) begin
                            m_mode = M_ERR; m_code = 2;
                        end else begin
                            m_have_wr = 1;
                            m_word = m_enc(op, rd, rs1, rs2, alu_mode, alu_func, cond, imm);
                            a = (BASE + m_count) % DEPTH;
                            m_final = (op == 4'd9) ? 1 : ((a == DEPTH - 1) ? 2 : 0);
                        end
                    end
                end
            end
        end
    end

    // compare process: all outputs every cycle, away from the rising edge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (m_live) begin
                chk("in_ready",   64'(in_ready),   64'(m_ready_f()));
                chk("mem_we",     64'(mem_we),     64'(m_have_wr));
                chk("mem_addr",   64'(mem_addr),   64'((BASE + m_count) % DEPTH));
                chk("mem_wdata",  64'(mem_wdata),  64'(m_word));
                chk("busy",       64'(busy),       64'(m_mode == M_RUN));
                chk("done",       64'(done),       64'(m_mode == M_DONE));
                chk("err",        64'(err),        64'(m_mode == M_ERR));
                chk("err_code",   64'(err_code),   64'(m_code));
                chk("word_count", 64'(word_count), 64'(m_count));
                if (rst_n && mem_we && !mem_stall)
                    wlog.push_back({mem_addr, mem_wdata});
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] f_op, input logic [2:0] f_rd, input logic [2:0] f_rs1,
                        input logic [2:0] f_rs2, input logic f_mode, input logic [2:0] f_func,
                        input logic [3:0] f_cond, input logic [15:0] f_imm);
        int n;
        bit got;
        op = f_op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2; alu_mode = f_mode;
        alu_func = f_func; cond = f_cond; imm = f_imm;
        in_valid = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 30) begin
            #1;
            got = (in_ready === 1'b1);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL send_accept op=%0d act=not_accepted exp=accepted", f_op);
        end
    endtask

    task automatic wait_end(input string nm);
        int n;
        n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!(done === 1'b1 || err === 1'b1)) begin
            total++; bad++;
            $display("FAIL %s act=no_end exp=done_or_err", nm);
        end
    endtask

    logic [AW+31:0] exp_log[4];

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_stall = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; alu_mode = 1'b0; alu_func = '0; cond = '0; imm = '0;

        chk("pin_movi",  64'(m_enc(4'd0, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h1234)), 64'(32'h0080_1234));
        chk("pin_halt",  64'(m_enc(4'd9, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h0000)), 64'(32'hD000_0000));
        chk("pin_alur",  64'(m_enc(4'd2, 3'd1, 3'd2, 3'd3, 1'b1, 3'd5, 4'h0, 16'h0000)), 64'(32'h7A53_0000));
        chk("pin_bcond", 64'(m_enc(4'd7, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 4'hA, 16'h0040)), 64'(32'hC540_0040));
        chk("pin_nop",   64'(m_enc(4'd8, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h0000)), 64'(32'hC800_0000));

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_addr",  64'(mem_addr), 64'(BASE));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_count", 64'(word_count), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // MOVI then HALT
        pulse_start();
        send(4'd0, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h1234);
        #1;
        chk("movi_we",   64'(mem_we),    64'(1));
        chk("movi_word", 64'(mem_wdata), 64'(32'h0080_1234));
        chk("movi_addr", 64'(mem_addr),  64'(0));
        send(4'd9, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h0000);
        #1;
        chk("halt_word", 64'(mem_wdata), 64'(32'hD000_0000));
        chk("halt_addr", 64'(mem_addr),  64'(1));
        @(negedge clk);
        #1;
        chk("halt_done",  64'(done),       64'(1));
        chk("halt_count", 64'(word_count), 64'(2));

        // ALU_R then bad ALU_I
        pulse_start();
        send(4'd2, 3'd1, 3'd2, 3'd3, 1'b1, 3'd5, 4'h0, 16'h0000);
        #1;
        chk("alur_word", 64'(mem_wdata), 64'(32'h7A53_0000));
        send(4'd3, 3'd0, 3'd0, 3'd0, 1'b0, 3'd6, 4'h0, 16'h0000);
        #1;
        chk("alui_err",   64'(err),        64'(1));
        chk("alui_code",  64'(err_code),   64'(2));
        chk("alui_count", 64'(word_count), 64'(1));
        chk("alui_we",    64'(mem_we),     64'(0));

        // BCOND then illegal op
        pulse_start();
        send(4'd7, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 4'hA, 16'h0040);
        #1;
        chk("bcond_word", 64'(mem_wdata), 64'(32'hC540_0040));
        send(4'd12, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h0000);
        #1;
        chk("ill_code",  64'(err_code),   64'(1));
        chk("ill_count", 64'(word_count), 64'(1));

        // stall on second word, then fourth-slot HALT
        pulse_start();
        wlog.delete();
        send(4'd0, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h1111);
        send(4'd0, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h2222);
        mem_stall = 1'b1;
        op = 4'd8; rd = '0; rs1 = '0; rs2 = '0; imm = '0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", 64'(in_ready),  64'(0));
            chk("stall_we",    64'(mem_we),    64'(1));
            chk("stall_addr",  64'(mem_addr),  64'(1));
            chk("stall_data",  64'(mem_wdata), 64'(32'h00C0_2222));
            @(negedge clk);
        end
        mem_stall = 1'b0;
        #1;
        chk("rel_ready", 64'(in_ready),  64'(1));
        chk("rel_data",  64'(mem_wdata), 64'(32'h00C0_2222));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("nop_addr", 64'(mem_addr),  64'(2));
        chk("nop_word", 64'(mem_wdata), 64'(32'hC800_0000));
        send(4'd9, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h0000);
        wait_end("stall_end");
        chk("top_halt_done",  64'(done),       64'(1));
        chk("top_halt_count", 64'(word_count), 64'(4));
        exp_log[0] = {2'd0, 32'h0040_1111};
        exp_log[1] = {2'd1, 32'h00C0_2222};
        exp_log[2] = {2'd2, 32'hC800_0000};
        exp_log[3] = {2'd3, 32'hD000_0000};
        chk("log_len", 64'(wlog.size()), 64'(4));
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("log_entry", 64'(wlog[i]), 64'(exp_log[i]));

        // address overflow
        pulse_start();
        repeat (4) send(4'd8, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h0000);
        wait_end("ovf_end");
        chk("ovf_err",   64'(err),        64'(1));
        chk("ovf_code",  64'(err_code),   64'(3));
        chk("ovf_count", 64'(word_count), 64'(4));

        // reset mid-stream with a stalled write
        pulse_start();
        send(4'd0, 3'd7, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'hFFFF);
        mem_stall = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mrst_we",    64'(mem_we),     64'(0));
        chk("mrst_addr",  64'(mem_addr),   64'(BASE));
        chk("mrst_wdata", 64'(mem_wdata),  64'(0));
        chk("mrst_busy",  64'(busy),       64'(0));
        chk("mrst_count", 64'(word_count), 64'(0));
        chk("mrst_ready", 64'(in_ready),   64'(0));
        rst_n = 1'b1;
        mem_stall = 1'b0;
        @(negedge clk);
        pulse_start();
        send(4'd8, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h0000);
        #1;
        chk("resume_addr", 64'(mem_addr), 64'(BASE));
        send(4'd9, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0, 16'h0000);
        wait_end("resume_end");
        @(negedge clk);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            start     = ($urandom_range(0, 5) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            op        = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            rd        = 3'($urandom);
            rs1       = 3'($urandom);
            rs2       = 3'($urandom);
            alu_mode  = 1'($urandom);
            alu_func  = 3'($urandom);
            cond      = 4'($urandom);
            imm       = 16'($urandom);
            mem_stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Streaming instruction encoder and program loader. Accepts decoded instruction field tuples over a valid/ready handshake and packs each into the 32-bit word format consumed by the core's instruction decoder. Writes each word into instruction memory at consecutive addresses, and stops on HALT or on an encoding or overflow error. It sits between the debug/boot host interface and the instruction memory write port.

## Interface

Parameters:
- ADDR_W, 8: instruction memory address width.
- BASE_ADDR, 0: first write address after start.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; begins a load (honoured in IDLE, DONE, ERR).
- in_valid  in  1  field tuple valid.
- in_ready  out  1  tuple accepted when in_valid & in_ready.
- op  in  4  operation code (see Operation).
- rd  in  3  result register, placed at I[24:22].
- rs1  in  3  op1 register, placed at I[21:19].
- rs2  in  3  op2 register, placed at I[18:16].
- alu_mode  in  1  placed at I[29] for ALU ops.
- alu_func  in  3  ALU function.
- cond  in  4  branch condition, placed at I[24:21] for BCOND.
- imm  in  16  immediate, placed at I[15:0].
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded word.
- mem_stall  in  1  memory not accepting; hold the write.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- err  out  1  state is ERR.
- err_code  out  2  0 none, 1 illegal op, 2 bad ALU_I func, 3 address overflow.
- word_count  out  ADDR_W+1  words written since start.

## Operation

- States: IDLE, RUN, DONE, ERR. Reset → IDLE.
- IDLE/DONE/ERR + start → RUN. This clears word_count and err_code and loads the address counter with BASE_ADDR.
- Encoding (fields not listed are 0; rd/rs1/rs2/imm are always placed in their slots):
  - op 0 MOVI: I[31:29]=000.
  - op 1 CMPI: I[31:29]=001, I[28]=1.
  - op 2 ALU_R: I[31:30]=01, I[29]=alu_mode, I[28]=1, I[27:25]=alu_func.
  - op 3 ALU_I: I[31:30]=01, I[29]=alu_mode, I[28:26]=000, I[25]=alu_func[0]. alu_func[2:1]≠0 is an error (code 2).
  - op 4 LOAD: I[31:30]=10, I[25]=0.
  - op 5 STORE: I[31:30]=10, I[25]=1.
  - op 6 B: I[31:30]=11, I[28:26]=000. cond is ignored and I[24:22] carries rd.
  - op 7 BCOND: I[31:30]=11, I[28:27]=00, I[26]=1, I[24:21]=cond. rd is not placed.
  - op 8 NOP: I[31:30]=11, I[28:27]=01.
  - op 9 HALT: I[31:30]=11, I[28]=1.
  - ops 10–15: illegal (code 1).
- An illegal or bad tuple is consumed but never written. FSM goes to ERR with the matching err_code.
- Accepted HALT is written, then the FSM goes to DONE once that write completes.
- Overflow: a write to address 2^ADDR_W−1 whose word is not HALT leads to ERR code 3 after that write completes.
- word_count increments on each completed write (mem_we & ~mem_stall).

## Timing

- Reset outputs: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, err_code=0, word_count=0.
- in_ready = (state==RUN) & ~(mem_we & mem_stall) & ~halt_pending & ~ovf_pending.
- Latency: a tuple accepted at edge N gives mem_we=1 with the word and address valid from edge N until edge N+1.
- mem_stall=1 while mem_we=1: mem_we, mem_addr and mem_wdata hold unchanged. The write completes on the first edge with mem_stall=0.
- Back-to-back: with mem_stall=0 continuously, one word is written per cycle.
- Address increments by 1 on each completed write.
- DONE/ERR are entered on the edge that completes the final write, or on the accept edge for an error tuple. in_ready is 0 from then on.
- start during RUN is ignored.
- rst_n=0 mid-load: the next edge forces the reset values and drops any pending write.

## Test plan

- Reset, start, stream MOVI(rd=2, imm=0x1234) then HALT → writes 0x00801234 at addr 0, then 0xD0000000 at addr 1. done=1, word_count=2.
- ALU_R alu_mode=1, alu_func=5, rd=1, rs1=2, rs2=3 → mem_wdata=0x7A530000. ALU_I with alu_func=6 → no write, err=1, err_code=2.
- BCOND cond=0xA, imm=0x0040 → 0xC5400040. op=12 → err_code=1 and word_count unchanged.
- mem_stall held 3 cycles on the second word → mem_we/addr/data stable for 4 cycles, in_ready=0, no word lost or duplicated.
- ADDR_W=2, BASE_ADDR=0: write 4 NOPs (0xC8000000 each) → after the addr-3 write, err_code=3 and word_count=4. A fourth-slot HALT instead → DONE.
- rst_n low mid-stream with mem_stall=1 → all outputs at reset values the next cycle; a new start resumes at BASE_ADDR.
